// File: rtl/y86_regfile_wb.sv
// y86_regfile_wb: Y86-64 register file and write-back stage.
// Ports:
//   clock_i, reset_n_i         rising-edge clock, asynchronous active-low reset
//   wb_valid_i                 instruction presented for write-back this cycle
//   icode_i, cnd_i, ra_i, rb_i instruction code, condition flag, register specifiers
//   val_e_i, val_m_i           ALU result (E port) and memory value (M port)
//   stat_i                     instruction status (1 AOK, 2 HLT, 3 ADR, 4 INS)
//   src_a_i, src_b_i           read addresses
//   rd_a_o, rd_b_o             combinational read data
//   dst_e_o, dst_m_o           decoded destinations, RNONE when not writing
//   halted_o                   sticky halt flag
//   retired_o                  committed-instruction counter (wraps)
module y86_regfile_wb #(
    parameter int                DATA_W   = 64,
    parameter int                NREGS    = 15,
    parameter int                IDX_W    = 4,
    parameter logic [IDX_W-1:0]  SP_IDX   = IDX_W'(4),
    parameter logic [DATA_W-1:0] RESET_SP = '0,
    parameter bit                BYPASS   = 1'b1,
    parameter int                CNT_W    = 32
) (
    input  logic              clock_i,
    input  logic              reset_n_i,
    input  logic              wb_valid_i,
    input  logic [3:0]        icode_i,
    input  logic              cnd_i,
    input  logic [IDX_W-1:0]  ra_i,
    input  logic [IDX_W-1:0]  rb_i,
    input  logic [DATA_W-1:0] val_e_i,
    input  logic [DATA_W-1:0] val_m_i,
    input  logic [2:0]        stat_i,
    input  logic [IDX_W-1:0]  src_a_i,
    input  logic [IDX_W-1:0]  src_b_i,
    output logic [DATA_W-1:0] rd_a_o,
    output logic [DATA_W-1:0] rd_b_o,
    output logic [IDX_W-1:0]  dst_e_o,
    output logic [IDX_W-1:0]  dst_m_o,
    output logic              halted_o,
    output logic [CNT_W-1:0]  retired_o
);
    localparam logic [IDX_W-1:0] RNONE = '1;
    localparam logic [2:0]       AOK   = 3'd1;

    typedef enum logic {RUN, HALT} state_t;

    state_t            state_q;
    logic [DATA_W-1:0] reg_q [NREGS];
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic              run, we, fault;
    logic [IDX_W-1:0]  e_raw, m_raw;

    always_comb begin
        // Holding reset low also blocks the enable, so nothing is forwarded or reported while in reset.
        run       = reset_n_i && state_q == RUN;
        we        = run && wb_valid_i && stat_i == AOK;
        fault     = run && wb_valid_i && stat_i != AOK;
        e_raw     = (icode_i == 4'h2) ? (cnd_i ? rb_i : RNONE) :
                    (icode_i == 4'h3 || icode_i == 4'h6) ? rb_i :
                    (icode_i >= 4'h8 && icode_i <= 4'hB) ? SP_IDX : RNONE;
        m_raw     = (icode_i == 4'h5 || icode_i == 4'hB) ? ra_i : RNONE;
        dst_e_o   = we ? e_raw : RNONE;
        dst_m_o   = we ? m_raw : RNONE;
        retired_d = we ? retired_q + CNT_W'(1) : retired_q;
        // M is checked before E so a popq %rsp read sees the value that will be stored.
        rd_a_o    = (32'(src_a_i) >= NREGS) ? '0 :
                    (BYPASS && we && dst_m_o == src_a_i) ? val_m_i :
                    (BYPASS && we && dst_e_o == src_a_i) ? val_e_i : reg_q[src_a_i];
        rd_b_o    = (32'(src_b_i) >= NREGS) ? '0 :
                    (BYPASS && we && dst_m_o == src_b_i) ? val_m_i :
                    (BYPASS && we && dst_e_o == src_b_i) ? val_e_i : reg_q[src_b_i];
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= RUN;
            retired_q <= '0;
            for (int i = 0; i < NREGS; i++)
                reg_q[i] <= (IDX_W'(i) == SP_IDX) ? RESET_SP : '0;
        end else begin
            state_q   <= fault ? HALT : state_q;
            retired_q <= retired_d;
            for (int i = 0; i < NREGS; i++)
                if (we && dst_m_o == IDX_W'(i))
                    reg_q[i] <= val_m_i;
                else if (we && dst_e_o == IDX_W'(i))
                    reg_q[i] <= val_e_i;
        end
    end

    assign halted_o  = state_q == HALT;
    assign retired_o = retired_q;
endmodule

// File: tb/tb_y86_regfile_wb.sv
// tb_y86_regfile_wb: randomized scoreboard bench for y86_regfile_wb (bypass and non-bypass instances).
module tb_y86_regfile_wb;
    localparam int CW = 4;

    logic        clk = 1'b0, rst_n = 1'b1, wb_valid = 1'b0, cnd = 1'b0;
    logic [3:0]  icode = 4'h0, ra = 4'hF, rb = 4'hF, src_a = 4'h0, src_b = 4'h0;
    logic [63:0] val_e = '0, val_m = '0;
    logic [2:0]  stat = 3'd1;

    logic [63:0]   rd_a, rd_b, nb_rd_a, nb_rd_b;
    logic [3:0]    dst_e, dst_m, nb_dst_e, nb_dst_m;
    logic          halted, nb_halted;
    logic [CW-1:0] retired, nb_retired;

    y86_regfile_wb #(.RESET_SP(64'h100), .BYPASS(1'b1), .CNT_W(CW)) u_dut (
        .clock_i(clk), .reset_n_i(rst_n), .wb_valid_i(wb_valid), .icode_i(icode), .cnd_i(cnd),
        .ra_i(ra), .rb_i(rb), .val_e_i(val_e), .val_m_i(val_m), .stat_i(stat),
        .src_a_i(src_a), .src_b_i(src_b), .rd_a_o(rd_a), .rd_b_o(rd_b),
        .dst_e_o(dst_e), .dst_m_o(dst_m), .halted_o(halted), .retired_o(retired));

    y86_regfile_wb #(.RESET_SP(64'h100), .BYPASS(1'b0), .CNT_W(CW)) u_nb (
        .clock_i(clk), .reset_n_i(rst_n), .wb_valid_i(wb_valid), .icode_i(icode), .cnd_i(cnd),
        .ra_i(ra), .rb_i(rb), .val_e_i(val_e), .val_m_i(val_m), .stat_i(stat),
        .src_a_i(src_a), .src_b_i(src_b), .rd_a_o(nb_rd_a), .rd_b_o(nb_rd_b),
        .dst_e_o(nb_dst_e), .dst_m_o(nb_dst_m), .halted_o(nb_halted), .retired_o(nb_retired));

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]    de, dm;
        logic [63:0]   ra, rb, na, nb;
        logic          h;
        logic [CW-1:0] r;
    } exp_t;

    exp_t          q[$];
    logic [63:0]   m_reg [15];
    bit            m_halt;
    logic [CW-1:0] m_ret;
    int            checks = 0, errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        foreach (m_reg[i]) m_reg[i] = (i == 4) ? 64'h100 : 64'h0;
        m_halt = 1'b0;
        m_ret  = '0;
    endfunction

    function automatic logic [63:0] rdv(input logic [63:0] arr [15], input logic [3:0] s);
        return (s >= 4'd15) ? 64'h0 : arr[s];
    endfunction

    // Drive one cycle at the falling edge, predict this cycle's outputs, then advance the model past the next rising edge.
    task automatic cyc(input bit r, input bit v, input logic [3:0] ic, input bit c,
                       input logic [3:0] a, input logic [3:0] b, input logic [63:0] e,
                       input logic [63:0] m, input logic [2:0] st,
                       input logic [3:0] sa, input logic [3:0] sb);
        exp_t        x;
        logic [63:0] nxt [15];
        logic [3:0]  de, dm;
        bit          en;
        @(negedge clk);
        wb_valid = v; icode = ic; cnd = c; ra = a; rb = b;
        val_e = e; val_m = m; stat = st; src_a = sa; src_b = sb; rst_n = r;
        if (!r) model_reset();
        en = r && v && !m_halt && st == 3'd1;
        de = 4'hF;
        dm = 4'hF;
        if (en)
            case (ic)
                4'h2:             de = c ? b : 4'hF;
                4'h3, 4'h6:       de = b;
                4'h5:             dm = a;
                4'h8, 4'h9, 4'hA: de = 4'd4;
                4'hB:             begin de = 4'd4; dm = a; end
                default:          ;
            endcase
        nxt = m_reg;
        if (de < 4'd15) nxt[de] = e;
        if (dm < 4'd15) nxt[dm] = m;
        x.de = de; x.dm = dm;
        x.ra = rdv(nxt, sa); x.rb = rdv(nxt, sb);
        x.na = rdv(m_reg, sa); x.nb = rdv(m_reg, sb);
        x.h = m_halt; x.r = m_ret;
        q.push_back(x);
        if (en) begin
            m_reg = nxt;
            m_ret = m_ret + 1'b1;
        end else if (r && v && !m_halt && st != 3'd1) begin
            m_halt = 1'b1;
        end
    endtask

    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            #4;
            while (q.size() > 0) begin
                x = q.pop_front();
                chk("dst_e", {60'h0, dst_e}, {60'h0, x.de});
                chk("dst_m", {60'h0, dst_m}, {60'h0, x.dm});
                chk("rd_a", rd_a, x.ra);
                chk("rd_b", rd_b, x.rb);
                chk("nb_rd_a", nb_rd_a, x.na);
                chk("nb_rd_b", nb_rd_b, x.nb);
                chk("halted", {63'h0, halted}, {63'h0, x.h});
                chk("retired", {60'h0, retired}, {60'h0, x.r});
            end
        end
    end

    initial begin
        logic [2:0] st;
        #1 rst_n = 1'b0;
        model_reset();
        cyc(0, 0, 4'h0, 0, 4'hF, 4'hF, 64'h0, 64'h0, 3'd1, 4'd4, 4'd0);
        cyc(1, 1, 4'h3, 0, 4'hF, 4'd2, 64'hDEAD, 64'h0, 3'd1, 4'd2, 4'd0);
        cyc(1, 1, 4'h2, 0, 4'hF, 4'd5, 64'h1234, 64'h0, 3'd1, 4'd5, 4'd2);
        cyc(1, 1, 4'h2, 1, 4'hF, 4'd5, 64'h7, 64'h0, 3'd1, 4'd5, 4'd0);
        cyc(1, 0, 4'h0, 0, 4'hF, 4'hF, 64'h0, 64'h0, 3'd1, 4'd5, 4'd2);
        cyc(1, 1, 4'hB, 0, 4'd4, 4'hF, 64'h108, 64'h55, 3'd1, 4'd4, 4'd0);
        cyc(1, 1, 4'hB, 0, 4'd3, 4'hF, 64'h200, 64'h66, 3'd1, 4'd4, 4'd3);
        cyc(1, 0, 4'h0, 0, 4'hF, 4'hF, 64'h0, 64'h0, 3'd1, 4'd4, 4'd3);
        cyc(1, 1, 4'h3, 0, 4'hF, 4'd1, 64'h9, 64'h0, 3'd2, 4'd1, 4'd0);
        cyc(1, 1, 4'h3, 0, 4'hF, 4'd1, 64'h77, 64'h0, 3'd1, 4'd1, 4'd0);
        cyc(1, 1, 4'h1, 0, 4'hF, 4'hF, 64'h0, 64'h0, 3'd1, 4'd1, 4'd4);
        cyc(0, 0, 4'h0, 0, 4'hF, 4'hF, 64'h0, 64'h0, 3'd1, 4'd1, 4'd4);
        for (int i = 0; i < 16; i++)
            cyc(1, 1, 4'h1, 0, 4'hF, 4'hF, 64'h0, 64'h0, 3'd1, 4'd0, 4'd4);
        cyc(1, 0, 4'h0, 0, 4'hF, 4'hF, 64'h0, 64'h0, 3'd1, 4'd0, 4'd4);
        for (int i = 0; i < 4; i++)
            cyc(1, 1, 4'h3, 0, 4'hF, 4'(i + 6), 64'(i + 100), 64'h0, 3'd1, 4'(i + 6), 4'd6);
        cyc(0, 1, 4'h3, 0, 4'hF, 4'd6, 64'hBAD, 64'h0, 3'd1, 4'd6, 4'd7);
        cyc(0, 1, 4'hB, 0, 4'd7, 4'hF, 64'hBAD, 64'hBAD, 3'd1, 4'd7, 4'd4);
        for (int i = 0; i < 400; i++) begin
            st = ($urandom_range(0, 49) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
            cyc($urandom_range(0, 39) != 0, $urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                {$urandom, $urandom}, {$urandom, $urandom}, st,
                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end
        repeat (2) @(negedge clk);
        chk("queue_drained", 64'(q.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/y86_regfile_wb.md
# y86_regfile_wb

Parametrised register file and write-back stage for the Y86-64 SEQ/PIPE cores. It decodes destination registers from `icode`/`ra`/`rb`/`cnd` and commits `val_e`/`val_m` on the rising clock edge through two write ports (E, M). It provides two read ports with optional same-cycle write bypass, a sticky halt state driven by instruction status, and a retired-instruction counter. It sits between memory stage outputs and decode stage register reads, and replaces the fixed 15x64 file-backed write-back.

## Interface
- `DATA_W`, 64, register and value width
- `NREGS`, 15, number of architectural registers; valid indices 0..NREGS-1
- `IDX_W`, 4, register index width; indices >= NREGS (incl. RNONE = 4'hF) mean "no register"
- `SP_IDX`, 4, stack-pointer index (%rsp)
- `RESET_SP`, 0, reset value of register SP_IDX; all other registers reset to 0
- `BYPASS`, 1, 1 = read ports forward same-cycle write data; 0 = read returns stored value only
- `CNT_W`, 32, retired-instruction counter width

Ports:
- `clock`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `wb_valid`  in  1  an instruction is presented for write-back this cycle
- `icode`  in  4  instruction code
- `cnd`  in  1  condition result (cmovXX)
- `ra`, `rb`  in  IDX_W  register specifiers
- `val_e`, `val_m`  in  DATA_W  ALU result / memory read value
- `stat`  in  3  instruction status: 1 AOK, 2 HLT, 3 ADR, 4 INS
- `src_a`, `src_b`  in  IDX_W  read addresses
- `rd_a`, `rd_b`  out  DATA_W  read data (combinational)
- `dst_e`, `dst_m`  out  IDX_W  decoded destinations this cycle (RNONE when none or not writing)
- `halted`  out  1  sticky halt flag
- `retired`  out  CNT_W  count of committed instructions

## Operation
- Destination decode, combinational:
  - icode 2 (cmovXX): dst_e = rb if cnd, else RNONE.
  - icode 3 (irmovq) and 6 (OPq): dst_e = rb.
  - icode 5 (mrmovq): dst_m = ra.
  - icode 8, 9, A (call, ret, pushq): dst_e = SP_IDX.
  - icode B (popq): dst_e = SP_IDX, dst_m = ra.
  - All other icodes: both RNONE.
- Write enable: `wb_valid` and state RUN and stat == AOK. When not enabled, dst_e/dst_m are driven RNONE.
- An index >= NREGS never writes and never alters any register.
- dst_e == dst_m (popq %rsp): the M port wins; the register receives val_m.
- Read: rd_x = reg[src_x]; src_x >= NREGS returns 0.
  - With BYPASS=1, a matching enabled write in the same cycle is forwarded to the read port, M before E.
- FSM states:
  - RUN (reset state).
  - HALT: entered on the edge where wb_valid=1 and stat != AOK. That instruction performs no write and is not counted.
  - HALT is absorbing until reset_n is asserted. In HALT, `wb_valid` is ignored and no writes or counts occur. Reads remain functional.
- `retired` increments by 1 on each edge with the write enable true, including instructions with no destination (e.g. rmmovq, nop). It wraps modulo 2^CNT_W.

## Timing
- Write latency: values are in the array after the rising edge on which they are presented. Without bypass they are readable in the following cycle; with BYPASS=1 they are readable in the same cycle.
- Both ports commit on the same edge; no partial commits.
- halted goes 1 immediately after the faulting edge and stays high.
- Reset (asynchronous, any time, including mid-write):
  - All registers go to 0 (SP_IDX to RESET_SP).
  - FSM goes to RUN, halted=0, retired=0.
  - No write is committed on an edge while reset_n=0.
- Deassertion of reset_n takes effect at the next rising edge; the first write is possible on that edge.

## Test plan
- Reset with RESET_SP=0x100, then read src_a=4, src_b=0 -> rd_a=0x100, rd_b=0; halted=0; retired=0.
- irmovq: icode=3, rb=2, val_e=0xDEAD, stat=1, one edge -> reg2=0xDEAD, retired=1. With BYPASS=1, src_a=2 in the same cycle -> rd_a=0xDEAD.
- cmovXX: icode=2, rb=5, cnd=0 -> reg5 unchanged, dst_e=0xF, retired increments. Then cnd=1, val_e=7 -> reg5=7.
- popq %rsp: icode=B, ra=4, val_e=0x108, val_m=0x55 -> reg4=0x55. popq ra=3 -> reg4=val_e, reg3=val_m.
- Halt: stat=2 with icode=3, rb=1, val_e=9 -> reg1 unchanged, halted=1, retired unchanged. Further valid AOK writes are ignored. Reset clears halted.
- Async reset asserted between edges during a stream of writes -> outputs reset immediately. Counter wrap with CNT_W=4: 16 commits -> retired=0.
